// File: rtl/iob_cache_axi_write_responder.sv
// AXI4 write-channel slave: one outstanding AW/W/B transaction, each accepted
// W beat is forwarded as a native-memory write. FIXED/INCR only; others drain with SLVERR.
module iob_cache_axi_write_responder #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int AXI_ID_W = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       axi_awvalid,
    input  logic [ADDR_W-1:0]          axi_awaddr,
    input  logic [7:0]                 axi_awlen,
    input  logic [2:0]                 axi_awsize,
    input  logic [1:0]                 axi_awburst,
    input  logic [AXI_ID_W-1:0]        axi_awid,
    output logic                       axi_awready,
    input  logic                       axi_wvalid,
    input  logic [DATA_W-1:0]          axi_wdata,
    input  logic [DATA_W/8-1:0]        axi_wstrb,
    input  logic                       axi_wlast,
    output logic                       axi_wready,
    output logic                       axi_bvalid,
    output logic [1:0]                 axi_bresp,
    output logic [AXI_ID_W-1:0]        axi_bid,
    input  logic                       axi_bready,
    output logic                       mem_valid,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0] mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_wstrb,
    input  logic                       mem_ready
);
    localparam int NBYTES_W = $clog2(DATA_W/8);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                state;
    logic [ADDR_W-1:0]     addr_reg;
    logic [2:0]            size_reg;
    logic [7:0]            len_reg;
    logic [7:0]            cnt;
    logic [1:0]            burst_reg;
    logic [AXI_ID_W-1:0]   id_reg;
    logic                  err;

    logic in_data;
    logic beat;
    logic last_cnt;
    logic len_mismatch;

    // W side stays combinational so a beat is accepted in the same cycle the
    // memory takes it; mem_ready only feeds wready, never mem_valid.
    assign in_data      = (state == DATA);
    assign axi_wready   = in_data && (err || mem_ready);
    assign beat         = axi_wvalid && axi_wready;
    assign last_cnt     = (cnt == len_reg);
    assign len_mismatch = last_cnt ^ axi_wlast;

    assign mem_valid = in_data && !err && axi_wvalid;
    assign mem_addr  = addr_reg[ADDR_W-1:NBYTES_W];
    assign mem_wdata = axi_wdata;
    assign mem_wstrb = (in_data && !err) ? axi_wstrb : '0;

    // NOTE: all state and registered outputs use <= so every flop samples the
    // pre-edge values; blocking here would let later statements see new values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr_reg    <= '0;
            size_reg    <= '0;
            len_reg     <= '0;
            cnt         <= '0;
            burst_reg   <= '0;
            id_reg      <= '0;
            err         <= 1'b0;
            axi_awready <= 1'b1;
            axi_bvalid  <= 1'b0;
            axi_bresp   <= RESP_OKAY;
            axi_bid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (axi_awvalid) begin
                        addr_reg    <= axi_awaddr;
                        size_reg    <= axi_awsize;
                        len_reg     <= axi_awlen;
                        burst_reg   <= axi_awburst;
                        id_reg      <= axi_awid;
                        cnt         <= '0;
                        err         <= (axi_awburst != BURST_FIXED && axi_awburst != BURST_INCR)
                                       || (axi_awsize > 3'(NBYTES_W));
                        axi_awready <= 1'b0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        if (burst_reg == BURST_INCR)
                            addr_reg <= addr_reg + (ADDR_W'(1) << size_reg);
                        cnt <= cnt + 8'd1;
                        if (len_mismatch)
                            err <= 1'b1;
                        // Early wlast or a count-terminated burst both end here.
                        if (last_cnt || axi_wlast) begin
                            state      <= RESP;
                            axi_bvalid <= 1'b1;
                            axi_bresp  <= (err || len_mismatch) ? RESP_SLVERR : RESP_OKAY;
                            axi_bid    <= id_reg;
                        end
                    end
                end
                RESP: begin
                    if (axi_bready) begin
                        state       <= IDLE;
                        err         <= 1'b0;
                        axi_bvalid  <= 1'b0;
                        axi_bresp   <= RESP_OKAY;
                        axi_bid     <= '0;
                        axi_awready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_cache_axi_write_responder.sv
// Bench for iob_cache_axi_write_responder: vector table of bursts plus hand-written
// latency and mid-burst reset sequences; memory writes are scored against a queue.
module tb_iob_cache_axi_write_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        axi_awvalid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic [1:0]  axi_awid;
    logic        axi_awready;
    logic        axi_wvalid;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wready;
    logic        axi_bvalid;
    logic [1:0]  axi_bresp;
    logic [1:0]  axi_bid;
    logic        axi_bready;
    logic        mem_valid;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  id;
        int          nbeats;
        int          wlast_idx;
        bit          mr_toggle;
        int          bdelay;
        logic [1:0]  exp_resp;
        int          exp_writes;
        logic [29:0] exp_waddr0;
        logic [29:0] exp_wstep;
    } vec_t;

    iob_cache_axi_write_responder #(.ADDR_W(32), .DATA_W(32), .AXI_ID_W(2)) dut (
        .clk(clk), .reset(reset),
        .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awid(axi_awid),
        .axi_awready(axi_awready),
        .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast), .axi_wready(axi_wready),
        .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
        .axi_bready(axi_bready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every accepted memory write must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && mem_valid && mem_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(mem_addr), 64'h1_0000_0000);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("mem_addr", 64'(mem_addr), 64'(e.addr));
                check("mem_wdata", 64'(mem_wdata), 64'(e.data));
                check("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 64'(axi_awready), 1);
        check({tag, "_wready"}, 64'(axi_wready), 0);
        check({tag, "_bvalid"}, 64'(axi_bvalid), 0);
        check({tag, "_bresp"}, 64'(axi_bresp), 0);
        check({tag, "_bid"}, 64'(axi_bid), 0);
        check({tag, "_mem_valid"}, 64'(mem_valid), 0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 0);
        check({tag, "_mem_wstrb"}, 64'(mem_wstrb), 0);
    endtask

    // Called just after a posedge; returns just after the AW handshake edge.
    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [1:0] id);
        axi_awvalid = 1'b1; axi_awaddr = addr; axi_awlen = len;
        axi_awsize = size; axi_awburst = burst; axi_awid = id;
        @(negedge clk);
        check("awready_idle", 64'(axi_awready), 1);
        check("wready_idle", 64'(axi_wready), 0);
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic [3:0] strb, input bit last,
                             input bit toggle, input bit exp_write, input logic [29:0] waddr,
                             input bit drain);
        bit done;
        done = 1'b0;
        axi_wvalid = 1'b1; axi_wdata = data; axi_wstrb = strb; axi_wlast = last;
        if (exp_write) sb.push_back('{waddr, data, strb});
        for (int c = 0; c < 32 && !done; c++) begin
            if (toggle) mem_ready = ~mem_ready;
            else        mem_ready = 1'b1;
            @(negedge clk);
            check("wready", 64'(axi_wready), 64'(drain ? 1'b1 : mem_ready));
            check("mem_valid", 64'(mem_valid), 64'(exp_write));
            done = axi_wready;
            @(posedge clk); #1;
        end
        check("beat_accepted", 64'(done), 1);
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
    endtask

    // Called just after the final beat edge; bvalid is required in the next cycle.
    task automatic wait_resp(input logic [1:0] exp_resp, input logic [1:0] exp_id, input int bdelay);
        mem_ready = 1'b1;
        @(negedge clk);
        check("bvalid", 64'(axi_bvalid), 1);
        check("bresp", 64'(axi_bresp), 64'(exp_resp));
        check("bid", 64'(axi_bid), 64'(exp_id));
        check("awready_resp", 64'(axi_awready), 0);
        check("wready_resp", 64'(axi_wready), 0);
        for (int i = 0; i < bdelay; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bvalid_hold", 64'(axi_bvalid), 1);
            check("bresp_hold", 64'(axi_bresp), 64'(exp_resp));
            check("bid_hold", 64'(axi_bid), 64'(exp_id));
            check("awready_hold", 64'(axi_awready), 0);
        end
        @(posedge clk); #1;
        axi_bready = 1'b1;
        @(negedge clk);
        check("bvalid_at_bready", 64'(axi_bvalid), 1);
        @(posedge clk); #1;
        axi_bready = 1'b0;
        @(negedge clk);
        check("awready_after_b", 64'(axi_awready), 1);
        check("bvalid_after_b", 64'(axi_bvalid), 0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[10];

    initial begin
        //           addr          len    sz    burst  id    nb   wl  tg  bd  resp   wr   waddr0          step
        vecs[0] = '{32'h0000_0100, 8'd0,   3'd2, 2'b01, 2'd1, 1,   0,  0,  0,  2'b00, 1,   30'h40,         30'd1};
        vecs[1] = '{32'h0000_0200, 8'd3,   3'd2, 2'b01, 2'd2, 4,   3,  1,  0,  2'b00, 4,   30'h80,         30'd1};
        vecs[2] = '{32'h0000_0040, 8'd2,   3'd2, 2'b00, 2'd3, 3,   2,  0,  0,  2'b00, 3,   30'h10,         30'd0};
        vecs[3] = '{32'h0000_0000, 8'd3,   3'd2, 2'b10, 2'd1, 4,   3,  1,  0,  2'b10, 0,   30'h0,          30'd0};
        vecs[4] = '{32'h0000_0000, 8'd3,   3'd3, 2'b01, 2'd0, 4,   3,  1,  0,  2'b10, 0,   30'h0,          30'd0};
        vecs[5] = '{32'h0000_0000, 8'd3,   3'd2, 2'b01, 2'd2, 2,   1,  0,  0,  2'b10, 2,   30'h0,          30'd1};
        vecs[6] = '{32'h0000_0010, 8'd1,   3'd2, 2'b01, 2'd3, 2,   1,  0,  5,  2'b00, 2,   30'h4,          30'd1};
        vecs[7] = '{32'h0000_0080, 8'd0,   3'd2, 2'b01, 2'd1, 1,  -1,  0,  0,  2'b10, 1,   30'h20,         30'd1};
        vecs[8] = '{32'hFFFF_FFFC, 8'd1,   3'd2, 2'b01, 2'd2, 2,   1,  1,  0,  2'b00, 2,   30'h3FFF_FFFF,  30'd1};
        vecs[9] = '{32'h0000_1000, 8'd255, 3'd2, 2'b01, 2'd1, 256, 255, 1, 0,  2'b00, 256, 30'h400,        30'd1};

        reset = 1'b1;
        axi_awvalid = 1'b0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0;
        axi_awburst = '0; axi_awid = '0;
        axi_wvalid = 1'b1; axi_wdata = '1; axi_wstrb = 4'hF; axi_wlast = 1'b0;
        axi_bready = 1'b0; mem_ready = 1'b1;
        #3;
        check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        axi_wvalid = 1'b0; axi_wstrb = '0;
        @(negedge clk);
        check_reset_outputs("post_reset");
        @(posedge clk); #1;

        // Minimum latency, with W presented together with AW in IDLE.
        axi_awvalid = 1'b1; axi_awaddr = 32'h100; axi_awlen = 8'd0; axi_awsize = 3'd2;
        axi_awburst = 2'b01; axi_awid = 2'd1;
        axi_wvalid = 1'b1; axi_wdata = 32'hDEAD_BEEF; axi_wstrb = 4'hF; axi_wlast = 1'b1;
        axi_bready = 1'b1; mem_ready = 1'b1;
        sb.push_back('{30'h40, 32'hDEAD_BEEF, 4'hF});
        @(negedge clk);
        check("lat_awready_n", 64'(axi_awready), 1);
        check("lat_wready_idle", 64'(axi_wready), 0);
        check("lat_mem_valid_idle", 64'(mem_valid), 0);
        @(posedge clk); #1;
        axi_awvalid = 1'b0;
        @(negedge clk);
        check("lat_wready_n1", 64'(axi_wready), 1);
        check("lat_awready_n1", 64'(axi_awready), 0);
        @(posedge clk); #1;
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        @(negedge clk);
        check("lat_bvalid_n2", 64'(axi_bvalid), 1);
        check("lat_bresp_n2", 64'(axi_bresp), 0);
        check("lat_bid_n2", 64'(axi_bid), 1);
        @(posedge clk); #1;
        axi_bready = 1'b0;
        @(negedge clk);
        check("lat_awready_n3", 64'(axi_awready), 1);
        check("lat_bvalid_n3", 64'(axi_bvalid), 0);
        check("lat_sb_empty", 64'(sb.size()), 0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            send_aw(v.addr, v.len, v.size, v.burst, v.id);
            for (int b = 0; b < v.nbeats; b++)
                send_beat($urandom, 4'($urandom_range(1, 15)), b == v.wlast_idx, v.mr_toggle,
                          b < v.exp_writes, v.exp_waddr0 + 30'(b) * v.exp_wstep, v.exp_writes == 0);
            wait_resp(v.exp_resp, v.id, v.bdelay);
            check("sb_empty", 64'(sb.size()), 0);
        end

        // Reset after beat 2 of a 4-beat INCR burst.
        send_aw(32'h200, 8'd3, 3'd2, 2'b01, 2'd1);
        send_beat(32'h1111_1111, 4'hF, 1'b0, 1'b0, 1'b1, 30'h80, 1'b0);
        send_beat(32'h2222_2222, 4'hF, 1'b0, 1'b0, 1'b1, 30'h81, 1'b0);
        reset = 1'b1;
        axi_wvalid = 1'b1; axi_wdata = 32'h3333_3333; axi_wstrb = 4'hF;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        axi_wvalid = 1'b0; axi_wstrb = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_b_after_reset", 64'(axi_bvalid), 0);
            @(posedge clk); #1;
        end
        check("reset_sb_empty", 64'(sb.size()), 0);
        send_aw(vecs[1].addr, vecs[1].len, vecs[1].size, vecs[1].burst, vecs[1].id);
        for (int b = 0; b < 4; b++)
            send_beat($urandom, 4'hF, b == 3, 1'b0, 1'b1, 30'h80 + 30'(b), 1'b0);
        wait_resp(2'b00, 2'd2, 0);
        check("final_sb_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/iob_cache_axi_write_responder.md
Name: iob_cache_axi_write_responder

Overview:
AXI4 write-channel responder (slave) that accepts AW/W/B transactions from an AXI initiator, such as the cache back-end write channel, and turns each data beat into a native-memory write.
Used as the memory-side endpoint in cache testbenches and as the bridge from an AXI back-end to a native SRAM/controller port.
Handles one outstanding transaction at a time.
Supports FIXED and INCR bursts of up to 256 beats and reports SLVERR for unsupported or malformed requests.

Parameters:
ADDR_W, 32, AXI byte-address width
DATA_W, 32, AXI and memory data width; power of 2, at least 8
AXI_ID_W, 1, AXI ID width
NBYTES_W, log2(DATA_W/8), derived localparam; byte-offset bits per word

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
axi_awvalid  in  1  write-address valid
axi_awaddr  in  ADDR_W  burst start byte address
axi_awlen  in  8  beats minus 1
axi_awsize  in  3  log2 of bytes per beat
axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
axi_awid  in  AXI_ID_W  transaction ID
axi_awready  out  1  write-address ready
axi_wvalid  in  1  write-data valid
axi_wdata  in  DATA_W  write data
axi_wstrb  in  DATA_W/8  byte strobes
axi_wlast  in  1  last beat of burst
axi_wready  out  1  write-data ready
axi_bvalid  out  1  write-response valid
axi_bresp  out  2  00 OKAY, 10 SLVERR
axi_bid  out  AXI_ID_W  response ID, equal to the latched awid
axi_bready  in  1  write-response ready
mem_valid  out  1  native write request
mem_addr  out  ADDR_W-NBYTES_W  word address
mem_wdata  out  DATA_W  write data
mem_wstrb  out  DATA_W/8  byte enables
mem_ready  in  1  native write accepted this cycle

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE. Beat counter, address register and error flag clear. Latched ID, length and burst type clear to 0.
- Outputs while reset is asserted or immediately after it deasserts: awready=1, wready=0, bvalid=0, bresp=00, bid=0, mem_valid=0, mem_addr=0, mem_wstrb=0.
- Reset mid-transaction aborts it. No B response is issued for the aborted transaction.
- Three-state FSM: IDLE, DATA, RESP.
- IDLE:
  - awready=1; all other handshake outputs are 0.
  - On awvalid&awready: latch awaddr, awlen, awburst, awid; clear the beat counter; go to DATA next cycle.
  - Set err=1 if awburst is not FIXED or INCR, or if awsize>NBYTES_W.
- DATA, err=0:
  - mem_valid = axi_wvalid; axi_wready = mem_ready.
  - mem_addr = addr_reg[ADDR_W-1:NBYTES_W]; mem_wdata = axi_wdata; mem_wstrb = axi_wstrb, passed through unmodified (narrow beats are the initiator's duty).
  - A beat completes on wvalid&wready.
- DATA, err=1:
  - axi_wready=1 and mem_valid=0. Beats are drained and discarded.
- On each completed beat:
  - INCR: addr_reg += 2**awsize, wrapping modulo 2**ADDR_W. FIXED: addr_reg unchanged.
  - counter += 1.
  - If counter==len_reg or wlast=1, go to RESP.
  - If (wlast=1 and counter!=len_reg) or (counter==len_reg and wlast=0), set err=1.
  - Early wlast ends the burst at that beat; that beat is still written if err was 0 before the beat.
- RESP:
  - bvalid=1; bresp = err ? 10 : 00; bid = latched ID.
  - awready=0 and wready=0.
  - On bready, go to IDLE next cycle and clear err.
  - bvalid, bresp and bid hold stable until bready.
- Minimum latency for a 1-beat burst with mem_ready=1 and bready=1: AW handshake at cycle N, W/mem handshake at N+1, bvalid at N+2, awready back at N+3.
- Simultaneous AW and W in IDLE: only AW is accepted; the W beat waits for DATA.
- wvalid in IDLE or RESP: not accepted (wready=0).
- The mem_* outputs are combinational from registered state and W inputs. No combinational path from mem_ready to mem_valid.

Test Plan:
- Single beat: awaddr=0x100, len=0, size=2, INCR, id=1, wdata=0xDEADBEEF, wstrb=F -> exactly one mem write at addr 0x40 with data 0xDEADBEEF; bresp=00, bid=1, bvalid at N+2.
- INCR 4-beat at 0x200 with mem_ready low on every other cycle -> mem writes at addrs 0x80..0x83 in order; wready mirrors mem_ready; bresp=00; no beats lost or duplicated.
- FIXED 3-beat at 0x40 -> three mem writes, all at addr 0x10; bresp=00.
- WRAP burst (awburst=10, len=3), or size=3 with DATA_W=32 -> 4 beats drained with wready=1, zero mem_valid pulses, bresp=10.
- INCR len=3 with wlast on beat 1 -> 2 mem writes (addrs 0x0 and 0x1), RESP entered immediately, bresp=10. Next AW is then accepted normally with bresp=00.
- bready held low 5 cycles -> bvalid/bresp/bid stable and awready=0 throughout. Separately: reset asserted mid-burst (after beat 2 of 4) -> outputs immediately at reset values, no bvalid afterwards, next transaction completes with OKAY.
